// File: rtl/booth_mult.sv
// rtl/booth_mult.sv - iterative radix-2 Booth signed multiplier, WIDTH x WIDTH -> WIDTH with overflow
module booth_mult #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_reg;
  logic [2*WIDTH:0]   p_reg;
  logic [CW-1:0]      count;

  logic [WIDTH:0]     hi_ext;
  logic [WIDTH:0]     a_ext;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   p_next;
  logic               last_step;
  logic               ovf_next;

  // The high half is widened by one bit so that subtracting the most negative
  // operand cannot wrap; the shift then absorbs that extra bit into P.
  always_comb begin
    hi_ext = {p_reg[2*WIDTH], p_reg[2*WIDTH:WIDTH+1]};
    a_ext  = {a_reg[WIDTH-1], a_reg};
    case (p_reg[1:0])
      2'b01:   sum = hi_ext + a_ext;
      2'b10:   sum = hi_ext - a_ext;
      default: sum = hi_ext;
    endcase
    p_next    = {sum, p_reg[WIDTH:1]};
    last_step = (count == CW'(WIDTH - 1));
    ovf_next  = ~((&p_next[2*WIDTH:WIDTH]) | ~(|p_next[2*WIDTH:WIDTH]));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      a_reg    <= '0;
      p_reg    <= '0;
      count    <= '0;
      out      <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= multiplicand;
            p_reg <= {{WIDTH{1'b0}}, multiplier, 1'b0};
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          p_reg <= p_next;
          count <= count + CW'(1);
          if (last_step) begin
            out      <= p_next[WIDTH:1];
            overflow <= ovf_next;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult.sv
// tb/tb_booth_mult.sv - randomized self-checking bench for booth_mult against a 64-bit arithmetic model
module tb_booth_mult;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] multiplicand;
  logic [W-1:0] multiplier;
  logic [W-1:0] out;
  logic         overflow;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_errors = 0;

  booth_mult #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out          (out),
    .overflow     (overflow),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: full signed product in 64 bits, low half and representability.
  function automatic void ref_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] o, output logic ov);
    longint p;
    longint lo_ext;
    p      = longint'($signed(a)) * longint'($signed(b));
    lo_ext = longint'($signed(p[W-1:0]));
    o      = p[W-1:0];
    ov     = (p != lo_ext);
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 9))
      0:       return '0;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 255)) - 32'd128;
      default: return $urandom;
    endcase
  endfunction

  // Runs one operation; optional second start pulse at inject_cyc (0 = none).
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int inject_cyc);
    logic [W-1:0] exp_out;
    logic         exp_ov;
    logic [W-1:0] got_out;
    logic         got_ov;
    int           done_cyc;
    int           busy_n;
    int           done_n;
    ref_mult(a, b, exp_out, exp_ov);
    done_cyc = -1;
    busy_n   = 0;
    done_n   = 0;
    got_out  = '0;
    got_ov   = 1'b0;
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= W + 4; cyc++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          got_out  = out;
          got_ov   = overflow;
        end
      end
      if (cyc == 1) begin
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
      end
      if (cyc == inject_cyc) begin
        start        = 1'b1;
        multiplicand = 32'd9;
        multiplier   = 32'd9;
      end else if (cyc == inject_cyc + 1) begin
        start = 1'b0;
      end
    end
    check({tag, "_out"}, 64'(got_out), 64'(exp_out));
    check({tag, "_ovf"}, 64'(got_ov), 64'(exp_ov));
    check({tag, "_done_cyc"}, 64'(done_cyc), 64'(W + 1));
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(W));
    check({tag, "_done_pulses"}, 64'(done_n), 64'd1);
    check({tag, "_out_held"}, 64'(out), 64'(exp_out));
    check({tag, "_ovf_held"}, 64'(overflow), 64'(exp_ov));
  endtask

  initial begin
    reset        = 1'b0;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) @(negedge clk);
    check("reset_out", 64'(out), 64'd0);
    check("reset_ovf", 64'(overflow), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    do_op("t1_7x-3", 32'd7, 32'hFFFF_FFFD, 0);
    do_op("t2_maxx2", 32'h7FFF_FFFF, 32'd2, 0);
    do_op("t3_minx-1", 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("t3_minx1", 32'h8000_0000, 32'd1, 0);
    do_op("t3_minxmin", 32'h8000_0000, 32'h8000_0000, 0);
    do_op("zero_a", 32'd0, 32'h1234_5678, 0);
    do_op("zero_b", 32'hDEAD_BEEF, 32'd0, 0);
    do_op("t4_ignore_busy", 32'd5, 32'd6, 10);
    do_op("t4_ignore_done", 32'd5, 32'd6, W + 1);

    // Abort mid-operation: outputs must clear at once, with no done pulse.
    @(negedge clk);
    multiplicand = 32'd11;
    multiplier   = 32'd13;
    start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5_abort_out", 64'(out), 64'd0);
    check("t5_abort_busy", 64'(busy), 64'd0);
    check("t5_abort_done", 64'(done), 64'd0);
    check("t5_abort_ovf", 64'(overflow), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    do_op("t5_restart", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0);

    for (int i = 0; i < 1400; i++) begin
      do_op("rand", pick_operand(), pick_operand(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
